// File: rtl/pipe_hazard_ctrl.sv
// Scoreboard-style hazard controller for the 5-stage pipeline: load-use stall,
// execute forwarding, decode write-back bypass and redirect kill strobes.
module pipe_hazard_ctrl #(
    parameter int AW       = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_RDY = 3,
    parameter int BR_STAGE = 2,
    parameter int CNT_W    = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         hold,
    input  logic                         valid_D,
    input  logic [AW-1:0]                rs_D,
    input  logic [AW-1:0]                rt_D,
    input  logic                         use_rs_D,
    input  logic                         use_rt_D,
    input  logic [AW-1:0]                dest_D,
    input  logic                         regwrite_D,
    input  logic                         memread_D,
    input  logic                         redirect,
    output logic                         stall_D,
    output logic [DEPTH:0]               kill,
    output logic [$clog2(DEPTH+1)-1:0]   fwd_rs_E,
    output logic [$clog2(DEPTH+1)-1:0]   fwd_rt_E,
    output logic                         byp_rs_D,
    output logic                         byp_rt_D,
    output logic [CNT_W-1:0]             stall_cnt,
    output logic [CNT_W-1:0]             flush_cnt
);

    localparam int SELW = $clog2(DEPTH+1);

    logic [DEPTH:1]         v_q, v_d;
    logic [DEPTH:1]         wr_q, wr_d;
    logic [DEPTH:1]         ld_q, ld_d;
    logic [DEPTH:1][AW-1:0] dest_q, dest_d;
    logic [AW-1:0]          rs_q, rs_d;
    logic [AW-1:0]          rt_q, rt_d;
    logic                   use_rs_q, use_rs_d;
    logic                   use_rt_q, use_rt_d;
    logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]       flush_cnt_q, flush_cnt_d;

    logic [DEPTH:1]         live;
    logic                   hazard;

    always_comb begin
        live = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            live[k] = v_q[k] & wr_q[k] & (dest_q[k] != '0);
        end
    end

    // A producer at stage k is still too young if its result appears at a
    // stage beyond k+1, which is where it sits when the consumer reaches E.
    always_comb begin
        hazard = 1'b0;
        for (int k = 1; k <= DEPTH - 1; k++) begin
            if (live[k] && (k + 1 < (ld_q[k] ? LOAD_RDY : 2))) begin
                if ((use_rs_D && dest_q[k] == rs_D) || (use_rt_D && dest_q[k] == rt_D)) begin
                    hazard = 1'b1;
                end
            end
        end
        stall_D = valid_D & ~redirect & hazard;
    end

    // Scanning from the oldest stage down lets the youngest producer win.
    always_comb begin
        fwd_rs_E = '0;
        fwd_rt_E = '0;
        for (int k = DEPTH; k >= 2; k--) begin
            if (live[k] && (k >= (ld_q[k] ? LOAD_RDY : 2))) begin
                if (use_rs_q && dest_q[k] == rs_q) fwd_rs_E = SELW'(k);
                if (use_rt_q && dest_q[k] == rt_q) fwd_rt_E = SELW'(k);
            end
        end
        byp_rs_D = use_rs_D & live[DEPTH] & (dest_q[DEPTH] == rs_D);
        byp_rt_D = use_rt_D & live[DEPTH] & (dest_q[DEPTH] == rt_D);
    end

    always_comb begin
        kill = '0;
        if (!hold) begin
            if (redirect) begin
                for (int k = 0; k <= BR_STAGE; k++) kill[k] = 1'b1;
            end else if (stall_D) begin
                kill[1] = 1'b1;
            end
        end
    end

    always_comb begin
        v_d         = v_q;
        wr_d        = wr_q;
        ld_d        = ld_q;
        dest_d      = dest_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        use_rs_d    = use_rs_q;
        use_rt_d    = use_rt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!hold) begin
            for (int k = DEPTH; k >= 2; k--) begin
                v_d[k]    = v_q[k-1];
                wr_d[k]   = wr_q[k-1];
                ld_d[k]   = ld_q[k-1];
                dest_d[k] = dest_q[k-1];
            end
            v_d[1]    = valid_D & ~stall_D & ~redirect;
            wr_d[1]   = regwrite_D;
            ld_d[1]   = memread_D;
            dest_d[1] = dest_D;
            rs_d      = rs_D;
            rt_d      = rt_D;
            use_rs_d  = use_rs_D;
            use_rt_d  = use_rt_D;
            // Everything younger than the branch is squashed; the branch moves on.
            if (redirect) begin
                for (int k = 2; k <= BR_STAGE; k++) v_d[k] = 1'b0;
            end
            if (stall_D && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
            if (redirect && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            v_q         <= '0;
            wr_q        <= '0;
            ld_q        <= '0;
            dest_q      <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            use_rs_q    <= 1'b0;
            use_rt_q    <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            v_q         <= v_d;
            wr_q        <= wr_d;
            ld_q        <= ld_d;
            dest_q      <= dest_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            use_rs_q    <= use_rs_d;
            use_rt_q    <= use_rt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

- Parametrised hazard controller for the 5-stage MIPS pipeline. Replaces the separate hazard and forwarding units with a single scoreboard-style block.
- Tracks destination registers of in-flight instructions across `DEPTH` post-decode stages. Each cycle it produces:
  - the load-use stall,
  - execute-operand forward selects,
  - decode-side write-back bypass flags,
  - per-pipeline-register kill (bubble) strobes for taken redirects.
- Adds global hold, a configurable load latency and redirect stage, and saturating stall/flush counters.

## Interface
Parameters:
- `AW`, 5: register address width.
- `DEPTH`, 3: tracked stages after decode (1=E, 2=M, …, DEPTH=W). Legal range 2..8.
- `LOAD_RDY`, 3: first stage index from which load data is forwardable. Legal range 2..DEPTH.
- `BR_STAGE`, 2: stage index in which `redirect` is resolved. Legal range 1..DEPTH-1.
- `CNT_W`, 16: performance counter width.

Ports:
- `clock`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-low reset.
- `hold`  in  1: global freeze; all pipeline registers hold.
- `valid_D`  in  1: decode slot holds a real instruction.
- `rs_D`, `rt_D`  in  AW: decode source addresses.
- `use_rs_D`, `use_rt_D`  in  1: the instruction actually reads rs / rt.
- `dest_D`  in  AW: decode destination address.
- `regwrite_D`  in  1: decode instruction writes a register.
- `memread_D`  in  1: decode instruction is a load.
- `redirect`  in  1: the instruction in stage BR_STAGE redirects the PC.
- `stall_D`  out  1: hold PC and IF_ID; insert a bubble into stage 1.
- `kill`  out  DEPTH+1: bit k=1 means the pipeline register feeding stage k loads a bubble this edge (bit 0 = IF_ID).
- `fwd_rs_E`, `fwd_rt_E`  out  SELW=$clog2(DEPTH+1): 0 selects the register-file value; k (2..DEPTH) selects the result of stage k.
- `byp_rs_D`, `byp_rt_D`  out  1: replace the register-file read with the stage-DEPTH write data.
- `stall_cnt`, `flush_cnt`  out  CNT_W: saturating event counters.

## Operation
- **Scoreboard.** Entry per stage k=1..DEPTH holds {v, wr, ld, dest}. Stage 1 additionally holds {rs, rt, use_rs, use_rt} of the execute instruction.
- **Live producer.** Entry k counts as a producer of address a when v & wr & dest==a & a!=0. Register 0 never hazards and never forwards.
- **Ready stage.** rdy(k) = LOAD_RDY if ld, else 2.
- **Load-use stall.** stall_D = valid_D & ~redirect & (any k in 1..DEPTH-1 with a live producer of a used source and k+1 < rdy(k)).
- **Forward select.** fwd_x_E = smallest k in 2..DEPTH with a live producer of the stage-1 source x, where use_x is set and k >= rdy(k). Otherwise 0. The youngest producer always wins.
- **Decode bypass.** byp_x_D = use_x_D & (stage DEPTH holds a live producer of x_D).
- **Advance.** Occurs every edge with hold=0:
  - entry k+1 ← entry k;
  - entry 1 ← decode fields with v = valid_D & ~stall_D & ~redirect.
- **Redirect.** When redirect=1 and hold=0:
  - kill[0..BR_STAGE] = 1;
  - after the edge, entries 1..BR_STAGE are invalid; the branch itself moves to stage BR_STAGE+1.
- **Stall.** stall_D=1 & hold=0 ⇒ kill[1]=1.
- **Priority.** hold > redirect > stall.
- **Hold.** While hold=1:
  - kill=0 and stall_D keeps its combinational value;
  - scoreboard and counters are frozen;
  - the source of redirect must keep it asserted until hold drops.
- **Counters.** Each saturates at all-ones.
  - stall_cnt += 1 on an edge with stall_D & ~hold.
  - flush_cnt += 1 on an edge with redirect & ~hold.

## Timing
- **Latency.** All outputs are combinational from inputs and registered state, with zero-cycle latency; all state updates on the rising edge of clock.
- **Reset.** Asserted asynchronously. Entries go invalid and counters clear, so stall_D=0, fwd=0, byp=0, kill=redirect-derived (0 when redirect=0).
- **Reset mid-operation.** All in-flight entries are discarded immediately; there is no partial shift.
- **Load-use bubbles.** A load followed by a dependent instruction stalls for LOAD_RDY-2 cycles: exactly one cycle at defaults.
- **Redirect during stall.** A simultaneous redirect and stall yields stall_D=0, and the decode instruction is killed.
- **Counter wrap.** At all-ones a counter holds its value; it never wraps.

## Test plan
- **ALU chain.** `add r3` then `sub r4,r3,r5` on consecutive cycles, DEPTH=3 → the next cycle has fwd_rs_E=2. The following cycle r3 is at stage 3 with fwd_rs_E=0; it is reached through byp_rs_D when it was in decode. stall_D stays 0.
- **Load-use.** `lw r2` then `add r6,r2,r2` → stall_D=1 for exactly 1 cycle and kill=4'b0010. Then fwd_rs_E=fwd_rt_E=3, and stall_cnt=1.
- **Zero register.** `lw r0` then a consumer of r0 → no stall; fwd=0 and byp=0.
- **Redirect.** redirect=1 with valid entries in stages 1..3 and BR_STAGE=2 → kill=4'b0111. After the edge, entries 1–2 are invalid, stage 3 keeps the branch, and flush_cnt increments. With a concurrent load-use, stall_D=0.
- **Hold.** Assert hold for 5 cycles in the middle of a load-use stall → scoreboard and counters are unchanged and kill=0. On release, exactly one stall cycle remains.
- **Reset and saturation.** Pull reset low with all stages valid → outputs return to reset values within the same cycle. Separately, force 2^CNT_W+3 stall events (e.g. with CNT_W=4) → stall_cnt holds at 4'hF.
